// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types
// Shared LC-3b type definitions used across the pipeline.
//   lc3b_word    : 16-bit machine word
//   lc3b_mem_op  : memory operation carried by an instruction into the MEM stage
// Small helpers classify an operation so every consumer decodes it identically.
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    LDW  = 3'd1,
    LDB  = 3'd2,
    STW  = 3'd3,
    STB  = 3'd4,
    LDI  = 3'd5,
    STI  = 3'd6
  } lc3b_mem_op;

  // Indirect operations fetch a pointer word before the real access
  function automatic logic isIndirect(input lc3b_mem_op op);
    return (op == LDI) || (op == STI);
  endfunction

  // Byte-sized accesses use the unaligned address and a single lane
  function automatic logic isByte(input lc3b_mem_op op);
    return (op == LDB) || (op == STB);
  endfunction

  function automatic logic isLoad(input lc3b_mem_op op);
    return (op == LDW) || (op == LDB) || (op == LDI);
  endfunction

  function automatic logic isStore(input lc3b_mem_op op);
    return (op == STW) || (op == STB) || (op == STI);
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage controller for the LC-3b pipeline. Accepts one memory instruction
// at a time, optionally performs the pointer fetch for LDI/STI, then performs
// the data access and pulses done so the MEM/WB register can load.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   valid_in, op_in     : instruction present in MEM and its memory operation
//   addr_in, wdata_in   : effective address and store data
//   mem_resp, mem_rdata : data-memory handshake and read data
//   mem_read/mem_write  : memory strobes (never both high)
//   mem_address         : access address (word-aligned for word accesses)
//   mem_wdata           : store data (byte replicated on both lanes for STB)
//   mem_byte_enable     : lane enables
//   stall_out           : hold upstream pipeline registers
//   done                : one-cycle load enable for MEM/WB
//   mdr_out, mar_out    : raw read word and final access address
// ---------------------------------------------------------------------------
module mem_access_ctrl
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  lc3b_mem_op op_in,
  input  lc3b_word   addr_in,
  input  lc3b_word   wdata_in,
  input  logic       mem_resp,
  input  lc3b_word   mem_rdata,
  output logic       mem_read,
  output logic       mem_write,
  output lc3b_word   mem_address,
  output lc3b_word   mem_wdata,
  output logic [1:0] mem_byte_enable,
  output logic       stall_out,
  output logic       done,
  output lc3b_word   mdr_out,
  output lc3b_word   mar_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IND  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     r_state;
  lc3b_mem_op r_op;
  lc3b_word   r_mar;
  lc3b_word   r_mdr;
  lc3b_word   r_wdata;

  logic w_accept;
  logic w_inInd;
  logic w_inAcc;
  logic w_busy;
  logic w_byteAcc;

  assign w_accept  = valid_in && (op_in != NONE);
  assign w_inInd   = (r_state == IND);
  assign w_inAcc   = (r_state == ACC);
  assign w_busy    = w_inInd || w_inAcc;
  assign w_byteAcc = w_inAcc && isByte(r_op);

  // Transaction sequencer. The instruction is captured once in IDLE and the
  // pipeline inputs are not looked at again until the next IDLE, so whatever
  // upstream does while stalled (or during the DONE cycle) cannot disturb or
  // re-trigger the access. In IND the returned pointer replaces the address,
  // which is why mar_out ends up holding the final access address. Stores
  // leave mdr untouched so the last loaded word stays visible downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= NONE;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= op_in;
            r_mar   <= addr_in;
            r_wdata <= wdata_in;
            r_state <= isIndirect(op_in) ? IND : ACC;
          end
        end
        IND: begin
          if (mem_resp) begin
            r_mar   <= mem_rdata;
            r_state <= ACC;
          end
        end
        ACC: begin
          if (mem_resp) begin
            if (isLoad(r_op)) begin
              r_mdr <= mem_rdata;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Memory-side outputs are decoded from the registered state only, so the
  // strobes cannot glitch with pipeline inputs and drop as soon as reset
  // forces IDLE. Outside IND/ACC the bus is parked at zero.
  // The pointer fetch in IND is always a full aligned word.
  assign mem_read  = w_inInd || (w_inAcc && isLoad(r_op));
  assign mem_write = w_inAcc && isStore(r_op);

  assign mem_address = !w_busy   ? '0 :
                       w_byteAcc ? r_mar :
                                   {r_mar[15:1], 1'b0};

  assign mem_byte_enable = !w_busy    ? 2'b00 :
                           !w_byteAcc ? 2'b11 :
                           r_mar[0]   ? 2'b10 : 2'b01;

  // The store byte is copied onto both lanes so the enabled lane is correct
  // whichever half of the word the address selects.
  assign mem_wdata = !mem_write    ? '0 :
                     (r_op == STB) ? {r_wdata[7:0], r_wdata[7:0]} :
                                     r_wdata;

  // The IDLE term lets the stall rise in the same cycle the instruction shows
  // up, before the state register has moved. Reset masks it so the pipeline
  // is released while the block is held in reset.
  assign stall_out = rst_n && (((r_state == IDLE) && w_accept) || w_busy);
  assign done      = (r_state == DONE);
  assign mdr_out   = r_mdr;
  assign mar_out   = r_mar;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl. A driver issues instructions and
// pushes the expected memory accesses and the expected MEM/WB result into
// queues, computed from a reference memory image. A memory responder serves
// the DUT from its own memory image with random wait states and compares
// every access it serves; a monitor compares mdr_out/mar_out whenever done
// is presented.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  lc3b_mem_op op_in = NONE;
  lc3b_word   addr_in = '0;
  lc3b_word   wdata_in = '0;
  logic       mem_resp = 1'b0;
  lc3b_word   mem_rdata = '0;
  logic       mem_read;
  logic       mem_write;
  lc3b_word   mem_address;
  lc3b_word   mem_wdata;
  logic [1:0] mem_byte_enable;
  logic       stall_out;
  logic       done;
  lc3b_word   mdr_out;
  lc3b_word   mar_out;

  mem_access_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .op_in          (op_in),
    .addr_in        (addr_in),
    .wdata_in       (wdata_in),
    .mem_resp       (mem_resp),
    .mem_rdata      (mem_rdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .stall_out      (stall_out),
    .done           (done),
    .mdr_out        (mdr_out),
    .mar_out        (mar_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       isWrite;
    lc3b_word   addr;
    logic [1:0] be;
    lc3b_word   data;
  } access_t;

  typedef struct {
    lc3b_word mdr;
    lc3b_word mar;
  } result_t;

  lc3b_word dutMem [32768];
  lc3b_word refMem [32768];
  access_t  accQ [$];
  result_t  resQ [$];
  lc3b_word modelMdr = '0;

  int checks = 0;
  int errors = 0;
  int forcedWait = -1;
  int maxWait = 3;
  bit respBlock = 1'b0;
  int busyCycles = 0;
  int waitLeft = -1;
  bit prevDone = 1'b0;

  // Single comparison point: every check counts here, mismatches print FAIL.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: derives the access sequence and result of one
  // instruction directly from the operation rules and the reference image.
  function automatic void modelIssue(input lc3b_mem_op op, input lc3b_word addr, input lc3b_word wd);
    lc3b_word   fin;
    access_t    a;
    result_t    r;
    fin = addr;
    if (op == LDI || op == STI) begin
      a.isWrite = 1'b0;
      a.addr    = {addr[15:1], 1'b0};
      a.be      = 2'b11;
      a.data    = '0;
      accQ.push_back(a);
      fin = refMem[addr[15:1]];
    end
    if (op == LDB || op == STB) begin
      a.addr = fin;
      a.be   = fin[0] ? 2'b10 : 2'b01;
    end else begin
      a.addr = {fin[15:1], 1'b0};
      a.be   = 2'b11;
    end
    if (op == STW || op == STB || op == STI) begin
      a.isWrite = 1'b1;
      a.data    = (op == STB) ? {wd[7:0], wd[7:0]} : wd;
      if (op == STB) begin
        if (fin[0]) refMem[fin[15:1]][15:8] = wd[7:0];
        else        refMem[fin[15:1]][7:0]  = wd[7:0];
      end else begin
        refMem[fin[15:1]] = wd;
      end
    end else begin
      a.isWrite = 1'b0;
      a.data    = '0;
      modelMdr  = refMem[fin[15:1]];
    end
    accQ.push_back(a);
    r.mdr = modelMdr;
    r.mar = fin;
    resQ.push_back(r);
  endfunction

  // Memory responder: serves strobes after a wait count, checks each served
  // access against the expected queue and answers stray mem_resp pulses
  // while the block is not requesting, which it must ignore.
  initial begin
    access_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_resp = 1'b0;
        waitLeft = -1;
        continue;
      end
      if (mem_read || mem_write) begin
        busyCycles++;
        checkOutput("strobe_overlap", {31'd0, mem_read & mem_write}, 32'd0);
        if (waitLeft < 0) waitLeft = (forcedWait >= 0) ? forcedWait : $urandom_range(0, maxWait);
        if (respBlock) begin
          mem_resp = 1'b0;
        end else if (waitLeft == 0) begin
          waitLeft = -1;
          mem_resp = 1'b1;
          if (accQ.size() == 0) begin
            checkOutput("unexpected_access", {16'd0, mem_address}, 32'hFFFF_FFFF);
          end else begin
            e = accQ.pop_front();
            checkOutput("access_kind", {30'd0, mem_read, mem_write}, {30'd0, ~e.isWrite, e.isWrite});
            checkOutput("access_addr", {16'd0, mem_address}, {16'd0, e.addr});
            checkOutput("access_be", {30'd0, mem_byte_enable}, {30'd0, e.be});
            if (e.isWrite) checkOutput("access_wdata", {16'd0, mem_wdata}, {16'd0, e.data});
          end
          if (mem_read) begin
            mem_rdata = dutMem[mem_address[15:1]];
          end else begin
            if (mem_byte_enable[1]) dutMem[mem_address[15:1]][15:8] = mem_wdata[15:8];
            if (mem_byte_enable[0]) dutMem[mem_address[15:1]][7:0]  = mem_wdata[7:0];
            mem_rdata = 16'($urandom);
          end
        end else begin
          waitLeft--;
          mem_resp  = 1'b0;
          mem_rdata = 16'($urandom);
        end
      end else begin
        waitLeft  = -1;
        mem_resp  = ($urandom_range(0, 3) == 0);
        mem_rdata = 16'($urandom);
      end
    end
  end

  // Result monitor: whenever done is presented, pop the expected MEM/WB
  // values and compare; done must never last two cycles.
  initial begin
    result_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevDone = 1'b0;
      end else begin
        if (done) begin
          checkOutput("done_single_cycle", {31'd0, prevDone}, 32'd0);
          if (resQ.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
          end else begin
            r = resQ.pop_front();
            checkOutput("mdr_out", {16'd0, mdr_out}, {16'd0, r.mdr});
            checkOutput("mar_out", {16'd0, mar_out}, {16'd0, r.mar});
          end
        end
        prevDone = done;
      end
    end
  end

  // Issues one instruction (entered just after a rising edge), keeps it held
  // or scrambles the inputs while the block is busy, then checks stall,
  // latency and that nothing is re-accepted after done.
  task automatic applyStimulus(input lc3b_mem_op op, input lc3b_word addr, input lc3b_word wd, input bit scramble);
    int  lat;
    bit  got;
    valid_in = 1'b1;
    op_in    = op;
    addr_in  = addr;
    wdata_in = wd;
    modelIssue(op, addr, wd);
    busyCycles = 0;
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    checkOutput("stall_accept", {31'd0, stall_out}, 32'd1);
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        valid_in = 1'($urandom);
        op_in    = lc3b_mem_op'(3'($urandom_range(0, 6)));
        addr_in  = 16'($urandom);
        wdata_in = 16'($urandom);
      end
      @(negedge clk);
      if (done) begin
        lat = c;
        got = 1'b1;
        break;
      end
      checkOutput("stall_busy", {31'd0, stall_out}, 32'd1);
    end
    if (!got) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", lat, 1 + busyCycles);
      checkOutput("stall_done", {31'd0, stall_out}, 32'd0);
      checkOutput("strobes_done", {30'd0, mem_read, mem_write}, 32'd0);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    op_in    = NONE;
    @(negedge clk);
    checkOutput("no_reaccept", {30'd0, mem_read, mem_write}, 32'd0);
    checkOutput("idle_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
    checkOutput({tag, "_stall"}, {31'd0, stall_out}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_mdr"}, {16'd0, mdr_out}, 32'd0);
    checkOutput({tag, "_mar"}, {16'd0, mar_out}, 32'd0);
    checkOutput({tag, "_addr"}, {16'd0, mem_address}, 32'd0);
    checkOutput({tag, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
    checkOutput({tag, "_be"}, {30'd0, mem_byte_enable}, 32'd0);
  endtask

  task automatic setWord(input lc3b_word addr, input lc3b_word val);
    dutMem[addr[15:1]] = val;
    refMem[addr[15:1]] = val;
  endtask

  // Watchdog so a wedged DUT still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed scenarios, idle behaviour, random traffic,
  // then a reset in the middle of an access.
  initial begin
    for (int i = 0; i < 32768; i++) begin
      dutMem[i] = 16'($urandom);
      refMem[i] = dutMem[i];
    end

    valid_in = 1'b1;
    op_in    = LDW;
    addr_in  = 16'h1234;
    repeat (3) @(posedge clk);
    #2;
    checkResetValues("reset");
    rst_n    = 1'b1;
    valid_in = 1'b0;
    op_in    = NONE;
    @(posedge clk);
    #1;

    setWord(16'h3004, 16'hBEEF);
    forcedWait = 2;
    applyStimulus(LDW, 16'h3005, 16'h0000, 1'b0);

    forcedWait = 0;
    applyStimulus(STB, 16'h2001, 16'h12AB, 1'b0);
    checkOutput("stb_mem_hi", {16'd0, dutMem[16'h2000 >> 1][15:8]}, 32'hAB);

    setWord(16'h1000, 16'h4000);
    setWord(16'h4000, 16'h5555);
    applyStimulus(LDI, 16'h1000, 16'h0000, 1'b1);

    setWord(16'h0A00, 16'h0B02);
    applyStimulus(STI, 16'h0A00, 16'h7777, 1'b1);
    checkOutput("sti_mem", {16'd0, dutMem[16'h0B02 >> 1]}, 32'h7777);
    forcedWait = -1;

    for (int c = 0; c < 5; c++) begin
      valid_in = 1'b1;
      op_in    = NONE;
      addr_in  = 16'($urandom);
      @(negedge clk);
      checkOutput("none_stall", {31'd0, stall_out}, 32'd0);
      checkOutput("none_done", {31'd0, done}, 32'd0);
      checkOutput("none_strobes", {30'd0, mem_read, mem_write}, 32'd0);
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 3; c++) begin
      valid_in = 1'b0;
      op_in    = lc3b_mem_op'(3'($urandom_range(1, 6)));
      @(negedge clk);
      checkOutput("invalid_stall", {31'd0, stall_out}, 32'd0);
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    op_in    = NONE;

    for (int t = 0; t < 150; t++) begin
      lc3b_mem_op op;
      lc3b_word   a;
      op = lc3b_mem_op'(3'($urandom_range(1, 6)));
      a  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = {12'h3F0, 4'($urandom)};
      applyStimulus(op, a, 16'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    respBlock = 1'b1;
    valid_in  = 1'b1;
    op_in     = LDW;
    addr_in   = 16'h0102;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("acc_read_before_reset", {31'd0, mem_read}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    accQ.delete();
    resQ.delete();
    modelMdr  = '0;
    respBlock = 1'b0;
    valid_in  = 1'b0;
    op_in     = NONE;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(LDW, 16'h0102, 16'h0000, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resq_empty", resQ.size(), 32'd0);
    checkOutput("accq_empty", accQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
